// File: rtl/rsa_job_loader_pkg.sv
// Shared definitions for the RSA job loader: default widths, FSM encoding, index sizing.
package rsa_job_loader_pkg;

  localparam int WIDTH_DEF = 4096;
  localparam int WORD_DEF  = 32;
  localparam int NW_DEF    = WIDTH_DEF / WORD_DEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rsa_word_serializer.sv
// Holds the captured engine result and streams it out one word per handshake, LS word first.
// out_data is a pure function of the held index, so it stays stable while out_ready is low.
module rsa_word_serializer
  import rsa_job_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORD  = WORD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] cypher,
  input  logic             enable,
  input  logic             clear,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WORD-1:0]  out_data,
  output logic             last_xfer
);

  localparam int NW = WIDTH / WORD;
  localparam int IW = idx_bits(NW);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  logic [NW-1:0][WORD-1:0] res_q;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    xfer;

  assign out_valid = enable;
  assign xfer      = enable && out_ready;
  assign last_xfer = xfer && (idx_q == LAST_IDX);
  assign out_data  = res_q[idx_q];

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (xfer) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= '0;
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
      if (capture) res_q <= cypher;
    end
  end

endmodule

// File: rtl/rsa_job_loader.sv
// Loads message/exponent/modulus word-serially into the rsa4k engine, runs it, then streams the result.
// Input accepted only while idle/loading; abort cancels the job and wins over every other event.
module rsa_job_loader
  import rsa_job_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORD  = WORD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  input  logic             abort,
  output logic             busy,
  output logic [31:0]      cycles,
  output logic             go,
  output logic [WIDTH-1:0] message,
  output logic [WIDTH-1:0] exponent,
  output logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] cypher,
  input  logic             done
);

  localparam int NW = WIDTH / WORD;
  localparam int IW = idx_bits(NW);
  localparam logic [IW-1:0] LAST_W = IW'(NW - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           widx_q, widx_d;
  logic [1:0]              osel_q, osel_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [31:0]             cycles_q, cycles_d;
  logic [NW-1:0][WORD-1:0] msg_q, exp_q, mod_q;
  logic                    in_xfer, last_word, run_done, ser_last;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign in_xfer   = in_valid && in_ready && !abort;
  assign last_word = (osel_q == 2'd2) && (widx_q == LAST_W);
  assign run_done  = (state_q == ST_RUN) && done && !abort;
  assign go        = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign cycles    = cycles_q;
  assign message   = msg_q;
  assign exponent  = exp_q;
  assign modulus   = mod_q;

  // The word counter is {operand select, word index}; it wraps to zero on the final word.
  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    osel_d   = osel_q;
    cnt_d    = '0;
    cycles_d = cycles_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (in_xfer) begin
          state_d = last_word ? ST_RUN : ST_LOAD;
          if (last_word) begin
            widx_d = '0;
            osel_d = '0;
          end else if (widx_q == LAST_W) begin
            widx_d = '0;
            osel_d = osel_q + 2'd1;
          end else begin
            widx_d = widx_q + IW'(1);
          end
        end
      end
      ST_RUN: begin
        cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        if (done) begin
          cycles_d = cnt_d;
          state_d  = ST_UNLOAD;
        end
      end
      ST_UNLOAD: if (ser_last) state_d = done ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:  if (!done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      widx_d   = '0;
      osel_d   = '0;
      cnt_d    = '0;
      cycles_d = cycles_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      widx_q   <= '0;
      osel_q   <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      osel_q   <= osel_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
    end else if (in_xfer) begin
      case (osel_q)
        2'd0:    msg_q[widx_q] <= in_data;
        2'd1:    exp_q[widx_q] <= in_data;
        default: mod_q[widx_q] <= in_data;
      endcase
    end
  end

  rsa_word_serializer #(.WIDTH(WIDTH), .WORD(WORD)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .capture   (run_done),
    .cypher    (cypher),
    .enable    (state_q == ST_UNLOAD),
    .clear     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .last_xfer (ser_last)
  );

endmodule

// File: tb/tb_rsa_job_loader.sv
// Directed bench for rsa_job_loader with a behavioural modexp engine of fixed latency.
module tb_rsa_job_loader;

  localparam int WIDTH = 4096;
  localparam int WORD  = 32;
  localparam int NW    = WIDTH / WORD;
  localparam int LAT   = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [WORD-1:0]  in_data;
  logic             out_valid, out_ready;
  logic [WORD-1:0]  out_data;
  logic             abort, busy, go, done;
  logic [31:0]      cycles;
  logic [WIDTH-1:0] message, exponent, modulus, cypher;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  eng_sticky = 0;
  bit  eng_release = 0;
  int  eng_cnt;

  always #5 clk = ~clk;

  rsa_job_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .abort(abort),
    .busy(busy), .cycles(cycles), .go(go), .message(message), .exponent(exponent),
    .modulus(modulus), .cypher(cypher), .done(done)
  );

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    logic [63:0] r;
    logic [63:0] x;
    r = 64'd1;
    x = {32'd0, b} % {32'd0, m};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % {32'd0, m};
      x = (x * x) % {32'd0, m};
    end
    return r[31:0];
  endfunction

  // Engine: done rises after LAT cycles of go; sticky mode holds it until released.
  initial begin
    done = 1'b0;
    cypher = '0;
    eng_cnt = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (!eng_sticky || eng_release) begin
          done = 1'b0;
          eng_cnt = 0;
        end
      end else if (go) begin
        eng_cnt++;
        if (eng_cnt == LAT) begin
          cypher = '0;
          cypher[31:0] = modexp(message[31:0], exponent[31:0], modulus[31:0]);
          done = 1'b1;
        end
      end else begin
        eng_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_job(input logic [31:0] m, input logic [31:0] e, input logic [31:0] md,
                          input int abort_at);
    int t;
    bit stalled;
    logic [31:0] op;
    stalled = 0;
    for (int k = 0; k < 3 * NW; k++) begin
      case (k / NW)
        0:       op = m;
        1:       op = e;
        default: op = md;
      endcase
      in_valid = 1'b1;
      in_data  = (k % NW == 0) ? op : 32'd0;
      if (k == abort_at) begin
        in_data = 32'hDEAD_BEEF;
        abort   = 1'b1;
      end
      t = 0;
      while (!in_ready && t < 50) begin
        tick();
        t++;
      end
      if (t == 50) stalled = 1;
      tick();
      if (k == abort_at) break;
    end
    abort = 1'b0;
    in_valid = 1'b0;
    chk("load_in_ready_stall", {63'd0, stalled}, 64'd0);
  endtask

  task automatic wait_result(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      tick();
      t++;
    end
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_go_low"}, {63'd0, go}, 64'd0);
    chk({tag, "_cycles"}, {32'd0, cycles}, 64'd10);
  endtask

  task automatic unload(input string tag, input logic [31:0] exp0, input bit toggle);
    int j;
    int t;
    bit rdy;
    j = 0;
    t = 0;
    rdy = 1;
    while (j < NW && t < 1000) begin
      out_ready = toggle ? rdy : 1'b1;
      chk($sformatf("%s_ov_w%0d", tag, j), {63'd0, out_valid}, 64'd1);
      chk($sformatf("%s_data_w%0d", tag, j), {32'd0, out_data}, (j == 0) ? {32'd0, exp0} : 64'd0);
      @(posedge clk);
      if (out_ready) j++;
      #1;
      rdy = ~rdy;
      t++;
    end
    out_ready = 1'b0;
    chk({tag, "_words"}, j, NW);
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_go", {63'd0, go}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_cycles", {32'd0, cycles}, 64'd0);
    chk("rst_message", {63'd0, |message}, 64'd0);
    reset = 1'b1;
    tick();
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // Job 1: 8^13 mod 77 = 0x32, full-rate unload.
    load_job(32'd8, 32'd13, 32'd77, -1);
    chk("j1_go", {63'd0, go}, 64'd1);
    chk("j1_busy", {63'd0, busy}, 64'd1);
    chk("j1_in_ready", {63'd0, in_ready}, 64'd0);
    chk("j1_msg", message[63:0], 64'd8);
    chk("j1_exp", exponent[63:0], 64'd13);
    chk("j1_mod", modulus[63:0], 64'd77);
    chk("j1_mod_hi", {63'd0, |modulus[WIDTH-1:64]}, 64'd0);
    wait_result("j1");
    unload("j1", 32'h0000_0032, 1'b0);
    chk("j1_end_busy", {63'd0, busy}, 64'd0);
    chk("j1_end_ov", {63'd0, out_valid}, 64'd0);

    // Job 2: 0x32^37 mod 77 = 8, out_ready toggling every cycle.
    load_job(32'h32, 32'd37, 32'd77, -1);
    wait_result("j2");
    unload("j2t", 32'h0000_0008, 1'b1);
    chk("j2_end_busy", {63'd0, busy}, 64'd0);

    // Abort on word 200 (exponent word 72); that word carries DEADBEEF and must be dropped.
    load_job(32'd5, 32'd3, 32'd99, 200);
    chk("ab_busy", {63'd0, busy}, 64'd0);
    chk("ab_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    repeat (20) begin
      tick();
      if (go || out_valid) seen = 1;
    end
    chk("ab_no_go", {63'd0, seen}, 64'd0);
    chk("ab_msg", message[63:0], 64'd5);
    chk("ab_exp", exponent[63:0], 64'd3);
    chk("ab_exp_w72", {32'd0, exponent[72*WORD +: WORD]}, 64'd0);
    chk("ab_mod_kept", modulus[63:0], 64'd77);
    chk("ab_cycles_kept", {32'd0, cycles}, 64'd10);
    load_job(32'h32, 32'd37, 32'd77, -1);
    wait_result("ab_fresh");
    unload("ab_fresh", 32'h0000_0008, 1'b0);

    // Engine keeps done high through the unload: expect DRAIN until done falls.
    eng_sticky = 1;
    load_job(32'd8, 32'd13, 32'd77, -1);
    wait_result("dr");
    unload("dr", 32'h0000_0032, 1'b0);
    chk("dr_busy", {63'd0, busy}, 64'd1);
    chk("dr_ov", {63'd0, out_valid}, 64'd0);
    repeat (5) tick();
    chk("dr_still_busy", {63'd0, busy}, 64'd1);
    chk("dr_go", {63'd0, go}, 64'd0);
    chk("dr_cycles", {32'd0, cycles}, 64'd10);
    eng_release = 1;
    tick();
    tick();
    chk("dr_idle", {63'd0, busy}, 64'd0);
    chk("dr_done_low", {63'd0, done}, 64'd0);
    eng_sticky = 0;
    eng_release = 0;

    // Reset while the engine is running.
    load_job(32'd8, 32'd13, 32'd77, -1);
    repeat (3) tick();
    chk("rr_go_pre", {63'd0, go}, 64'd1);
    reset = 1'b0;
    #1;
    chk("rr_go", {63'd0, go}, 64'd0);
    chk("rr_busy", {63'd0, busy}, 64'd0);
    chk("rr_cycles", {32'd0, cycles}, 64'd0);
    chk("rr_msg", {63'd0, |message}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (go || out_valid || busy) seen = 1;
    end
    chk("rr_quiet", {63'd0, seen}, 64'd0);
    chk("rr_in_ready", {63'd0, in_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rsa_job_loader.md
RSA_JOB_LOADER -- requirements
Module: rsa_job_loader

Interface
REQ-001 Parameter: WIDTH, 4096, operand/result width in bits; the engine port width.
REQ-002 Parameter: WORD, 32, host bus word width; WIDTH SHALL be an integer multiple of WORD; NW = WIDTH/WORD.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  in  1  host word valid.
REQ-006 Port: in_ready  out  1  loader accepts a word this cycle.
REQ-007 Port: in_data  in  WORD  operand word; transfer occurs when in_valid&&in_ready.
REQ-008 Port: out_valid  out  1  result word valid.
REQ-009 Port: out_ready  in  1  host accepts a result word; transfer occurs when out_valid&&out_ready.
REQ-010 Port: out_data  out  WORD  result word.
REQ-011 Port: abort  in  1  synchronous job cancel.
REQ-012 Port: busy  out  1  high in any state other than IDLE.
REQ-013 Port: cycles  out  32  engine latency of the last completed job.
REQ-014 Port: go  out  1  engine start, to rsa4k go.
REQ-015 Port: message, exponent, modulus  out  WIDTH each  engine operands, registered.
REQ-016 Port: cypher  in  WIDTH  engine result.
REQ-017 Port: done  in  1  engine completion.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, UNLOAD, DRAIN.
REQ-019 in_ready SHALL be 1 in IDLE and LOAD only; 0 elsewhere.
REQ-020 Input stream SHALL be 3*NW words: message, exponent, modulus, in that order, each least-significant word first; word k writes operand k/NW, bits [(k%NW)*WORD +: WORD].
REQ-021 IDLE -> LOAD on the first accepted word; the word counter SHALL count 0..3*NW-1 and clear on leaving LOAD.
REQ-022 LOAD -> RUN the cycle after the word 3*NW-1 transfer; go SHALL be 1 on that next cycle and held 1 throughout RUN.
REQ-023 In RUN, the cycle counter SHALL increment every cycle go=1, including the cycle done is sampled high; it SHALL start from 1 on the first RUN cycle.
REQ-024 On done=1 in RUN: cypher SHALL be captured into the result register, cycles SHALL be updated with the counter value, go SHALL be 0 the next cycle, state -> UNLOAD.
REQ-025 In UNLOAD, out_valid=1 and out_data = result word j (LS first, j=0..NW-1); j advances only on transfer; out_data/out_valid SHALL hold stable while out_ready=0.
REQ-026 After transfer of word NW-1: -> DRAIN if done=1, else -> IDLE; DRAIN -> IDLE when done=0.
REQ-027 abort=1 in any state SHALL force IDLE next cycle, go=0, out_valid=0, word/result counters cleared; operand and cycles registers retained; abort has priority over all other events.
REQ-028 abort coincident with a word transfer SHALL discard that word.
REQ-029 done=1 outside RUN SHALL be ignored.
REQ-030 Counter overflow: cycle counter SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-031 On reset=0: state IDLE, go=0, out_valid=0, in_ready=1 once released, busy=0, cycles=0, message/exponent/modulus=0, result=0, all counters 0.
REQ-032 Reset asserted mid-job SHALL abandon it with no further go or out_valid pulses after release.

Structure
REQ-033 State encoding, WIDTH/WORD defaults, and NW SHALL live in the shared parameter include used by rsa4k.
REQ-034 The block SHALL be one module; one sub-module rsa_word_serializer (result shift/index + out handshake) is permitted.

Verification
REQ-035 Load message=8, exponent=13, modulus=77 into rsa4k -> go high until done; out words: word0=32'h00000032, words1..127=0; cycles>0.
REQ-036 Reload message=0x32, exponent=37, modulus=77 -> word0=32'h00000008, rest 0.
REQ-037 out_ready toggled 1/0 every cycle during UNLOAD -> 128 transfers, data stable while stalled, no word lost or repeated.
REQ-038 abort asserted at word 200 of load -> IDLE next cycle, go never rises; fresh 384-word load then completes normally.
REQ-039 reset=0 for 2 cycles while in RUN -> go=0, busy=0, cycles=0, out_valid stays 0 after release.
REQ-040 Behavioural engine holding done=1 for 5 cycles after go drops -> DRAIN entered, IDLE reached only after done=0, no second capture.
